axi4_lite_demux: RTL and testbench



---
 rtl/axi4_lite_demux.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi4_lite_demux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_demux.sv
// AXI4-Lite 1-to-N demultiplexer: one master routed to NUM_SLAVES slaves by an address field,
// with DECERR for unmapped addresses and a per-path watchdog that answers SLVERR for hung slaves.
module axi4_lite_demux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 28,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ADDR_WIDTH-1:0]                    m_awaddr,
  input  logic [2:0]                               m_awprot,
  input  logic                                     m_awvalid,
  output logic                                     m_awready,
  input  logic [DATA_WIDTH-1:0]                    m_wdata,
  input  logic [DATA_WIDTH/8-1:0]                  m_wstrb,
  input  logic                                     m_wvalid,
  output logic                                     m_wready,
  output logic [1:0]                               m_bresp,
  output logic                                     m_bvalid,
  input  logic                                     m_bready,
  input  logic [ADDR_WIDTH-1:0]                    m_araddr,
  input  logic [2:0]                               m_arprot,
  input  logic                                     m_arvalid,
  output logic                                     m_arready,
  output logic [DATA_WIDTH-1:0]                    m_rdata,
  output logic [1:0]                               m_rresp,
  output logic                                     m_rvalid,
  input  logic                                     m_rready,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]    s_awaddr,
  output logic [NUM_SLAVES-1:0][2:0]               s_awprot,
  output logic [NUM_SLAVES-1:0]                    s_awvalid,
  input  logic [NUM_SLAVES-1:0]                    s_awready,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]    s_wdata,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH/8-1:0]  s_wstrb,
  output logic [NUM_SLAVES-1:0]                    s_wvalid,
  input  logic [NUM_SLAVES-1:0]                    s_wready,
  input  logic [NUM_SLAVES-1:0][1:0]               s_bresp,
  input  logic [NUM_SLAVES-1:0]                    s_bvalid,
  output logic [NUM_SLAVES-1:0]                    s_bready,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]    s_araddr,
  output logic [NUM_SLAVES-1:0][2:0]               s_arprot,
  output logic [NUM_SLAVES-1:0]                    s_arvalid,
  input  logic [NUM_SLAVES-1:0]                    s_arready,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]    s_rdata,
  input  logic [NUM_SLAVES-1:0][1:0]               s_rresp,
  input  logic [NUM_SLAVES-1:0]                    s_rvalid,
  output logic [NUM_SLAVES-1:0]                    s_rready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_RESP} r_state_t;

  // One-hot route for an address; all-zero means unmapped.
  function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [3:0] idx;
    decode = '0;
    idx = addr[SEL_LSB+3:SEL_LSB];
    for (int i = 0; i < NUM_SLAVES; i++) if (idx == 4'(i)) decode[i] = 1'b1;
  endfunction

  w_state_t w_state_reg, w_state_next;
  logic [ADDR_WIDTH-1:0] aw_addr_reg, aw_addr_next;
  logic [2:0] aw_prot_reg, aw_prot_next;
  logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [SW-1:0] w_strb_reg, w_strb_next;
  logic [NUM_SLAVES-1:0] w_route_reg, w_route_next, s_awvalid_reg, s_awvalid_next;
  logic [NUM_SLAVES-1:0] s_wvalid_reg, s_wvalid_next, s_bready_reg, s_bready_next;
  logic aw_done_reg, aw_done_next, w_done_reg, w_done_next, m_bvalid_reg, m_bvalid_next;
  logic [1:0] m_bresp_reg, m_bresp_next, b_resp_sel;
  logic [CW-1:0] w_cnt_reg, w_cnt_next;
  logic aw_hs, w_hs, b_hs, w_timeout;

  r_state_t r_state_reg, r_state_next;
  logic [ADDR_WIDTH-1:0] ar_addr_reg, ar_addr_next;
  logic [2:0] ar_prot_reg, ar_prot_next;
  logic [NUM_SLAVES-1:0] r_route_reg, r_route_next, s_arvalid_reg, s_arvalid_next;
  logic [NUM_SLAVES-1:0] s_rready_reg, s_rready_next;
  logic m_rvalid_reg, m_rvalid_next;
  logic [1:0] m_rresp_reg, m_rresp_next, r_resp_sel;
  logic [DATA_WIDTH-1:0] r_data_reg, r_data_next, r_data_sel;
  logic [CW-1:0] r_cnt_reg, r_cnt_next;
  logic ar_hs, r_hs, r_timeout;

  assign m_awready = (w_state_reg == W_IDLE) & m_awvalid & m_wvalid;
  assign m_wready  = m_awready;
  assign m_arready = (r_state_reg == R_IDLE) & m_arvalid;
  assign m_bvalid  = m_bvalid_reg;
  assign m_bresp   = m_bresp_reg;
  assign m_rvalid  = m_rvalid_reg;
  assign m_rresp   = m_rresp_reg;
  assign m_rdata   = r_data_reg;
  assign s_awvalid = s_awvalid_reg;
  assign s_wvalid  = s_wvalid_reg;
  assign s_bready  = s_bready_reg;
  assign s_arvalid = s_arvalid_reg;
  assign s_rready  = s_rready_reg;

  // Payload is steered only to the routed slave; everyone else sees zero.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_fanout
    assign s_awaddr[gi] = w_route_reg[gi] ? aw_addr_reg : '0;
    assign s_awprot[gi] = w_route_reg[gi] ? aw_prot_reg : '0;
    assign s_wdata[gi]  = w_route_reg[gi] ? w_data_reg  : '0;
    assign s_wstrb[gi]  = w_route_reg[gi] ? w_strb_reg  : '0;
    assign s_araddr[gi] = r_route_reg[gi] ? ar_addr_reg : '0;
    assign s_arprot[gi] = r_route_reg[gi] ? ar_prot_reg : '0;
  end

  always_comb begin
    b_resp_sel = '0;
    r_resp_sel = '0;
    r_data_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_route_reg[i]) b_resp_sel = s_bresp[i];
      if (r_route_reg[i]) begin
        r_resp_sel = s_rresp[i];
        r_data_sel = s_rdata[i];
      end
    end
  end

  assign aw_hs     = |(s_awvalid_reg & s_awready);
  assign w_hs      = |(s_wvalid_reg & s_wready);
  assign b_hs      = |(s_bready_reg & s_bvalid);
  assign ar_hs     = |(s_arvalid_reg & s_arready);
  assign r_hs      = |(s_rready_reg & s_rvalid);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_reg >= CNT_LIMIT);
  assign r_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt_reg >= CNT_LIMIT);

  always_comb begin
    w_state_next = w_state_reg;   aw_addr_next  = aw_addr_reg;   aw_prot_next   = aw_prot_reg;
    w_data_next  = w_data_reg;    w_strb_next   = w_strb_reg;    w_route_next   = w_route_reg;
    s_awvalid_next = s_awvalid_reg; s_wvalid_next = s_wvalid_reg; s_bready_next = s_bready_reg;
    aw_done_next = aw_done_reg;   w_done_next   = w_done_reg;    m_bvalid_next  = m_bvalid_reg;
    m_bresp_next = m_bresp_reg;   w_cnt_next    = w_cnt_reg;
    case (w_state_reg)
      W_IDLE: if (m_awready) begin
        aw_addr_next = m_awaddr;
        aw_prot_next = m_awprot;
        w_data_next  = m_wdata;
        w_strb_next  = m_wstrb;
        if (|decode(m_awaddr)) begin
          w_route_next   = decode(m_awaddr);
          s_awvalid_next = decode(m_awaddr);
          s_wvalid_next  = decode(m_awaddr);
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          w_cnt_next     = '0;
          w_state_next   = W_FWD;
        end else begin
          m_bresp_next  = RESP_DECERR;
          m_bvalid_next = 1'b1;
          w_state_next  = W_RESP;
        end
      end
      W_FWD: begin
        w_cnt_next   = (w_cnt_reg == '1) ? w_cnt_reg : w_cnt_reg + CW'(1);
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if (aw_hs) s_awvalid_next = '0;
        if (w_hs) s_wvalid_next = '0;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
          s_bready_next = w_route_reg;
          w_state_next  = W_WAIT;
        end else if (w_timeout) begin
          s_awvalid_next = '0;
          s_wvalid_next  = '0;
          m_bresp_next   = RESP_SLVERR;
          m_bvalid_next  = 1'b1;
          w_state_next   = W_RESP;
        end
      end
      W_WAIT: begin
        w_cnt_next = (w_cnt_reg == '1) ? w_cnt_reg : w_cnt_reg + CW'(1);
        if (b_hs || w_timeout) begin
          s_bready_next = '0;
          m_bresp_next  = b_hs ? b_resp_sel : RESP_SLVERR;
          m_bvalid_next = 1'b1;
          w_state_next  = W_RESP;
        end
      end
      default: if (m_bready) begin
        m_bvalid_next = 1'b0;
        w_route_next  = '0;
        w_state_next  = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;   ar_addr_next = ar_addr_reg;   ar_prot_next  = ar_prot_reg;
    r_route_next = r_route_reg;   s_arvalid_next = s_arvalid_reg; s_rready_next = s_rready_reg;
    m_rvalid_next = m_rvalid_reg; m_rresp_next = m_rresp_reg;   r_data_next   = r_data_reg;
    r_cnt_next   = r_cnt_reg;
    case (r_state_reg)
      R_IDLE: if (m_arready) begin
        ar_addr_next = m_araddr;
        ar_prot_next = m_arprot;
        if (|decode(m_araddr)) begin
          r_route_next   = decode(m_araddr);
          s_arvalid_next = decode(m_araddr);
          r_cnt_next     = '0;
          r_state_next   = R_FWD;
        end else begin
          r_data_next   = '0;
          m_rresp_next  = RESP_DECERR;
          m_rvalid_next = 1'b1;
          r_state_next  = R_RESP;
        end
      end
      R_FWD: begin
        r_cnt_next = (r_cnt_reg == '1) ? r_cnt_reg : r_cnt_reg + CW'(1);
        if (ar_hs) begin
          s_arvalid_next = '0;
          s_rready_next  = r_route_reg;
          r_state_next   = R_WAIT;
        end else if (r_timeout) begin
          s_arvalid_next = '0;
          r_data_next    = '0;
          m_rresp_next   = RESP_SLVERR;
          m_rvalid_next  = 1'b1;
          r_state_next   = R_RESP;
        end
      end
      R_WAIT: begin
        r_cnt_next = (r_cnt_reg == '1) ? r_cnt_reg : r_cnt_reg + CW'(1);
        if (r_hs || r_timeout) begin
          s_rready_next = '0;
          r_data_next   = r_hs ? r_data_sel : '0;
          m_rresp_next  = r_hs ? r_resp_sel : RESP_SLVERR;
          m_rvalid_next = 1'b1;
          r_state_next  = R_RESP;
        end
      end
      default: if (m_rready) begin
        m_rvalid_next = 1'b0;
        r_route_next  = '0;
        r_state_next  = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;  aw_addr_reg <= '0;  aw_prot_reg <= '0;  w_data_reg <= '0;
      w_strb_reg <= '0;  w_route_reg <= '0;  s_awvalid_reg <= '0;  s_wvalid_reg <= '0;
      s_bready_reg <= '0;  aw_done_reg <= 1'b0;  w_done_reg <= 1'b0;  m_bvalid_reg <= 1'b0;
      m_bresp_reg <= '0;  w_cnt_reg <= '0;
      r_state_reg <= R_IDLE;  ar_addr_reg <= '0;  ar_prot_reg <= '0;  r_route_reg <= '0;
      s_arvalid_reg <= '0;  s_rready_reg <= '0;  m_rvalid_reg <= 1'b0;  m_rresp_reg <= '0;
      r_data_reg <= '0;  r_cnt_reg <= '0;
    end else begin
      w_state_reg <= w_state_next;  aw_addr_reg <= aw_addr_next;  aw_prot_reg <= aw_prot_next;
      w_data_reg <= w_data_next;  w_strb_reg <= w_strb_next;  w_route_reg <= w_route_next;
      s_awvalid_reg <= s_awvalid_next;  s_wvalid_reg <= s_wvalid_next;
      s_bready_reg <= s_bready_next;  aw_done_reg <= aw_done_next;  w_done_reg <= w_done_next;
      m_bvalid_reg <= m_bvalid_next;  m_bresp_reg <= m_bresp_next;  w_cnt_reg <= w_cnt_next;
      r_state_reg <= r_state_next;  ar_addr_reg <= ar_addr_next;  ar_prot_reg <= ar_prot_next;
      r_route_reg <= r_route_next;  s_arvalid_reg <= s_arvalid_next;
      s_rready_reg <= s_rready_next;  m_rvalid_reg <= m_rvalid_next;
      m_rresp_reg <= m_rresp_next;  r_data_reg <= r_data_next;  r_cnt_reg <= r_cnt_next;
    end
  end

endmodule

// File: tb/tb_axi4_lite_demux.sv
// Directed bench for axi4_lite_demux: a vector table of single transactions with a scripted
// slave, plus a hand-written concurrent read/write sequence with a mid-transaction reset.
module tb_axi4_lite_demux;
  localparam int N = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] m_awaddr;  logic [2:0] m_awprot;  logic m_awvalid, m_awready;
  logic [31:0] m_wdata;   logic [3:0] m_wstrb;   logic m_wvalid, m_wready;
  logic [1:0]  m_bresp;   logic m_bvalid, m_bready;
  logic [31:0] m_araddr;  logic [2:0] m_arprot;  logic m_arvalid, m_arready;
  logic [31:0] m_rdata;   logic [1:0] m_rresp;   logic m_rvalid, m_rready;
  logic [N-1:0][31:0] s_awaddr;  logic [N-1:0][2:0] s_awprot;  logic [N-1:0] s_awvalid, s_awready;
  logic [N-1:0][31:0] s_wdata;   logic [N-1:0][3:0] s_wstrb;   logic [N-1:0] s_wvalid, s_wready;
  logic [N-1:0][1:0]  s_bresp;   logic [N-1:0] s_bvalid, s_bready;
  logic [N-1:0][31:0] s_araddr;  logic [N-1:0][2:0] s_arprot;  logic [N-1:0] s_arvalid, s_arready;
  logic [N-1:0][31:0] s_rdata;   logic [N-1:0][1:0] s_rresp;   logic [N-1:0] s_rvalid, s_rready;

  int checks = 0;
  int failures = 0;

  axi4_lite_demux #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(N), .SEL_LSB(28),
                    .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    int          stall;
    bit          hung;
    int          hold;
    logic [3:0]  mask;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic slaves_idle();
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
    s_arready = '0; s_rvalid = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int c, resp_cyc, idx, a_cyc, d_cyc, rdy_first;
    bit a_done, d_done, r_done;
    logic [3:0] seen;
    string tag;
    tag = $sformatf("v%0d", n);
    idx = 0;
    for (int i = 0; i < N; i++) if (v.mask[i]) idx = i;
    @(negedge clk);
    if (v.wr) begin
      m_awaddr = v.addr; m_awprot = 3'b001; m_wdata = v.data; m_wstrb = v.strb;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
    end else begin
      m_araddr = v.addr; m_arprot = 3'b101; m_arvalid = 1'b1;
    end
    #1;
    chk({tag, "_accept"}, v.wr ? {m_awready, m_wready} : {m_arready, m_arready}, 2'b11);
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
    c = 1; resp_cyc = 0; a_cyc = 0; d_cyc = 0; rdy_first = 0;
    a_done = 0; d_done = 0; r_done = 0; seen = '0;
    while (c < 40) begin
      if (c == 1) begin
        chk({tag, "_valid_c1"}, v.wr ? s_awvalid : s_arvalid, v.mask);
        if (v.mask != 0 && v.wr) begin
          chk({tag, "_s_awaddr"}, s_awaddr[idx], v.addr);
          chk({tag, "_s_wdata"}, s_wdata[idx], v.data);
          chk({tag, "_s_wstrb_prot"}, {s_wstrb[idx], s_awprot[idx]}, {v.strb, 3'b001});
          chk({tag, "_other_awaddr"}, s_awaddr[(idx + 1) % N], 32'h0);
        end else if (v.mask != 0) begin
          chk({tag, "_s_araddr"}, {s_araddr[idx], s_arprot[idx]}, {v.addr, 3'b101});
          chk({tag, "_other_araddr"}, s_araddr[(idx + 1) % N], 32'h0);
        end
      end
      if (v.wr) begin
        seen |= s_awvalid;
        if (s_awvalid != 0) a_cyc++;
        if (s_wvalid != 0) d_cyc++;
        if (s_bready != 0 && rdy_first == 0) rdy_first = c;
        if (m_bvalid) begin resp_cyc = c; break; end
      end else begin
        seen |= s_arvalid;
        if (s_arvalid != 0) a_cyc++;
        if (s_rready != 0 && rdy_first == 0) rdy_first = c;
        if (m_rvalid) begin resp_cyc = c; break; end
      end
      s_awready = (c > v.stall) ? '1 : '0;
      s_arready = (c > v.stall) ? '1 : '0;
      s_wready  = '1;
      s_bvalid  = (v.wr && !v.hung && a_done && d_done && !r_done) ? v.mask : '0;
      s_rvalid  = (!v.wr && !v.hung && a_done && !r_done) ? v.mask : '0;
      s_bresp[idx] = v.sresp;
      s_rresp[idx] = v.sresp;
      s_rdata[idx] = v.srdata;
      #1;
      if ((|(s_awvalid & s_awready)) || (|(s_arvalid & s_arready))) a_done = 1;
      if (|(s_wvalid & s_wready)) d_done = 1;
      if ((|(s_bvalid & s_bready)) || (|(s_rvalid & s_rready))) r_done = 1;
      @(negedge clk);
      c++;
    end
    chk({tag, "_resp_cycle"}, resp_cyc, v.exp_cyc);
    chk({tag, "_resp"}, v.wr ? m_bresp : m_rresp, v.exp_resp);
    if (!v.wr) chk({tag, "_rdata"}, m_rdata, v.exp_rdata);
    chk({tag, "_valid_seen"}, seen, v.mask);
    chk({tag, "_addr_valid_cycles"}, a_cyc, (v.mask != 0) ? v.stall + 1 : 0);
    if (v.wr) chk({tag, "_wvalid_cycles"}, d_cyc, (v.mask != 0) ? 1 : 0);
    chk({tag, "_ready_first"}, rdy_first, (v.mask != 0) ? v.stall + 2 : 0);
    chk({tag, "_slave_quiet"}, v.wr ? {s_awvalid, s_wvalid, s_bready} : {4'h0, s_arvalid, s_rready}, 12'h0);
    slaves_idle();
    for (int h = 0; h < v.hold; h++) begin
      if (v.wr) begin
        m_awaddr = 32'h0000_0004; m_wdata = 32'h0; m_awvalid = 1'b1; m_wvalid = 1'b1;
      end else begin
        m_araddr = 32'h0000_0004; m_arvalid = 1'b1;
      end
      #1;
      chk({tag, "_stall_ready"}, v.wr ? (m_awready | m_wready) : m_arready, 1'b0);
      chk({tag, "_hold_resp"}, v.wr ? {m_bvalid, m_bresp} : {m_rvalid, m_rresp}, {1'b1, v.exp_resp});
      @(negedge clk);
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
    m_bready = v.wr; m_rready = !v.wr;
    @(negedge clk);
    m_bready = 1'b0; m_rready = 1'b0;
    chk({tag, "_released"}, v.wr ? m_bvalid : m_rvalid, 1'b0);
    $display("txn %0d wr=%0b addr=%h resp_cycle=%0d resp=%0b", n, v.wr, v.addr, resp_cyc,
             v.wr ? m_bresp : m_rresp);
  endtask

  initial begin
    // wr, addr, data, strb, sresp, srdata, stall, hung, hold, mask, exp_resp, exp_rdata, exp_cyc
    vecs[0] = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, 0, 1'b0, 0, 4'b0010, 2'b00, 32'h0, 3};
    vecs[1] = '{1'b0, 32'h5000_0004, 32'h0, 4'h0, 2'b00, 32'h1234_5678, 0, 1'b0, 0, 4'b0000, 2'b11, 32'h0, 1};
    vecs[2] = '{1'b1, 32'h2000_0100, 32'h1234_5678, 4'h3, 2'b01, 32'h0, 3, 1'b0, 0, 4'b0100, 2'b01, 32'h0, 6};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D, 0, 1'b0, 0, 4'b0001, 2'b00, 32'hCAFE_F00D, 3};
    vecs[4] = '{1'b0, 32'h3000_0040, 32'h0, 4'h0, 2'b00, 32'h9999_9999, 0, 1'b1, 0, 4'b1000, 2'b10, 32'h0, 18};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_A5A5, 4'hF, 2'b10, 32'h0, 0, 1'b0, 5, 4'b0001, 2'b10, 32'h0, 3};
    vecs[6] = '{1'b1, 32'hF000_0000, 32'h5555_AAAA, 4'hF, 2'b00, 32'h0, 0, 1'b0, 0, 4'b0000, 2'b11, 32'h0, 1};
    vecs[7] = '{1'b1, 32'h3000_0000, 32'h0F0F_0F0F, 4'h8, 2'b00, 32'h0, 0, 1'b1, 0, 4'b1000, 2'b10, 32'h0, 18};
    vecs[8] = '{1'b0, 32'h2000_0010, 32'h0, 4'h0, 2'b00, 32'h0BAD_F00D, 2, 1'b0, 0, 4'b0100, 2'b00, 32'h0BAD_F00D, 5};
    vecs[9] = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 2'b01, 32'h1111_2222, 0, 1'b0, 2, 4'b0010, 2'b01, 32'h1111_2222, 3};

    rst = 1'b0;
    m_awaddr = '0; m_awprot = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
    m_bready = 1'b0; m_araddr = '0; m_arprot = '0; m_arvalid = 1'b0; m_rready = 1'b0;
    slaves_idle();
    repeat (3) @(negedge clk);
    chk("reset_master", {m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_bresp, m_rresp}, 9'h0);
    chk("reset_slave_ctl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 20'h0);
    chk("reset_data", {|s_awaddr, |s_wdata, |s_wstrb, |s_awprot, |s_araddr, |s_arprot, |m_rdata}, 7'h0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Concurrent write to slave 0 and read from slave 3, then reset while the write waits.
    @(negedge clk);
    m_awaddr = 32'h0000_0000; m_awprot = 3'b000; m_wdata = 32'h55; m_wstrb = 4'hF;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_araddr = 32'h3000_0000; m_arprot = 3'b000; m_arvalid = 1'b1;
    #1;
    chk("conc_accept", {m_awready, m_arready}, 2'b11);
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
    chk("conc_fwd", {s_awvalid, s_arvalid}, {4'b0001, 4'b1000});
    s_awready = '1; s_wready = '1; s_arready = '1;
    @(negedge clk);
    chk("conc_wait", {s_bready, s_rready}, {4'b0001, 4'b1000});
    s_awready = '0; s_wready = '0; s_arready = '0;
    s_rvalid = 4'b1000; s_rdata[3] = 32'h7777_0003; s_rresp[3] = 2'b00;
    @(negedge clk);
    s_rvalid = '0;
    chk("conc_rresp", {m_rvalid, m_rresp, m_rdata}, {1'b1, 2'b00, 32'h7777_0003});
    chk("conc_write_waiting", {m_bvalid, s_bready}, {1'b0, 4'b0001});
    m_rready = 1'b1;
    @(negedge clk);
    m_rready = 1'b0;
    chk("conc_read_done", {m_rvalid, s_bready}, {1'b0, 4'b0001});
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ctl", {m_bvalid, m_rvalid, m_bresp, m_rresp, s_awvalid, s_wvalid, s_bready,
                          s_arvalid, s_rready}, 26'h0);
    chk("rst_async_data", {|s_awaddr, |s_wdata, |s_wstrb, |s_araddr, |m_rdata}, 5'h0);
    @(negedge clk);
    rst = 1'b1;
    s_bvalid = 4'b0001; s_bresp[0] = 2'b01;
    @(negedge clk);
    s_bvalid = '0; s_bresp = '0;
    chk("rst_discard", {m_bvalid, s_bready}, 5'h0);
    run_vec(vecs[0], 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
